pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 32, PC width in bits; word-addressed.
- JW, 26, jump field width; JW < AW.
- RAS_DEPTH, 4, return-address-stack entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- branch  in  1  branch taken (branch & zero).
- branch_off  in  AW  signed word offset.
- jump  in  1  absolute jump.
- link  in  1  with jump: push return address (JAL).
- ret  in  1  pop RAS into PC (JR-return).
- jump_value  in  JW  jump target field.
- pc  out  AW  current PC.
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- ras_ovf  out  1  sticky push-while-full flag.
- ras_unf  out  1  sticky pop-while-empty flag.

Function
REQ-003 Each non-stalled cycle SHALL apply exactly one PC update, by priority: ret > jump > branch > sequential.
REQ-004 Sequential: pc <= pc + 1, modulo 2^AW; wrap from all-ones to 0 SHALL be silent.
REQ-005 Branch: pc <= pc + branch_off + 1, modulo 2^AW; branch_off is two's complement.
REQ-006 Jump: pc <= {pc[AW-1:JW], jump_value}; upper bits come from the current PC, not pc+1.
REQ-007 Jump with link=1 SHALL also push pc + 1 onto the RAS in the same cycle; link without jump SHALL be ignored.
REQ-008 ret with ras_empty=0: pc <= top of RAS; ras_count decrements.
REQ-009 ret with ras_empty=1: pc <= pc + 1; ras_unf sets; ras_count stays 0.
REQ-010 Push with ras_full=1 SHALL overwrite the oldest entry (circular RAS).
- ras_count stays RAS_DEPTH.
- ras_ovf sets.
- The newest entry becomes the top.
REQ-011 ret and jump+link in the same cycle: ret wins; no push occurs; the jump is ignored.
REQ-012 stall=1 SHALL hold pc, RAS contents, ras_count and the sticky flags, regardless of other inputs.
REQ-013 ras_full and ras_empty SHALL be combinational decodes of ras_count.
REQ-014 Sticky flags SHALL clear only on reset.
REQ-015 pc SHALL be a registered output; an update is visible one clock after the qualifying edge, and there is no combinational path from inputs to pc.

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for clk, set:
- pc = RESET_PC
- ras_count = 0, ras_empty = 1, ras_full = 0
- ras_ovf = 0, ras_unf = 0
REQ-017 RAS storage contents are don't-care after reset; they SHALL never be observable while ras_empty = 1.
REQ-018 Reset asserted mid-operation, including during stall, SHALL override all other inputs.
REQ-019 The first update after deassertion SHALL occur on the first rising clk edge with reset low.

Verification
REQ-020 Reset, then 3 cycles with no controls -> pc = 0, 1, 2, 3; ras_empty = 1.
REQ-021 At pc = 10, branch = 1, branch_off = -5 (all ones except bit pattern for -5) -> pc = 6. At pc = 2^AW-1, sequential -> pc = 0.
REQ-022 At pc = 0x0400_0010, jump + link, jump_value = 0x100 -> pc = 0x0400_0100, RAS top = 0x0400_0011. Then ret -> pc = 0x0400_0011, ras_empty = 1.
REQ-023 RAS_DEPTH = 4, five JALs from return addresses A1..A5 -> ras_ovf = 1. Then five rets -> PCs A5, A4, A3, A2, then sequential; ras_unf = 1.
REQ-024 stall = 1 with branch, jump and ret all asserted -> pc and ras_count unchanged. Same cycle with ret and jump+link, unstalled -> pops; ras_count decrements by 1.
REQ-025 Reset asserted asynchronously between clk edges after pushes -> pc = RESET_PC and flags/count cleared before the next edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with branch/jump/return sequencing and a circular return-address stack.
// Priority per cycle: ret > jump > branch > sequential; stall freezes all state.
module pc_unit #(
  parameter int AW = 32,
  parameter int JW = 26,
  parameter int RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch,
  input  logic [AW-1:0] branch_off,
  input  logic          jump,
  input  logic          link,
  input  logic          ret,
  input  logic [JW-1:0] jump_value,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] ras_count,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          ras_ovf,
  output logic          ras_unf
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, top_idx;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          do_push, do_pop;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  assign pc_inc    = pc_q + AW'(1);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);
  // wp_q is the next write slot; the top of stack sits just below it
  assign top_idx   = wp_q - PW'(1);
  assign do_pop    = !stall && ret && !ras_empty;
  assign do_push   = !stall && !ret && jump && link;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!stall) begin
      if (ret) begin
        if (ras_empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_idx];
          cnt_d = cnt_q - CW'(1);
          wp_d  = top_idx;
        end
      end else if (jump) begin
        pc_d = {pc_q[AW-1:JW], jump_value};
      end else if (branch) begin
        pc_d = pc_inc + branch_off;
      end else begin
        pc_d = pc_inc;
      end
      // Full push wraps onto the oldest slot, so count saturates and wp still advances
      if (do_push) begin
        wp_d = wp_q + PW'(1);
        if (ras_full) ovf_d = 1'b1;
        else          cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage needs no reset: entries are only read while the count is non-zero
  always_ff @(posedge clk) begin
    if (do_push) ras_q[wp_q] <= pc_inc;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, RAS push/pop/wrap, stall and async reset.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, link, ret;
  logic [31:0] branch_off;
  logic [25:0] jump_value;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int n_cmp = 0;
  int n_mis = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_off(branch_off), .jump(jump), .link(link), .ret(ret),
    .jump_value(jump_value), .pc(pc), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ras(input string tag, input int cnt, input logic ovf, input logic unf);
    chk({tag, ".count"}, 64'(ras_count), 64'(cnt));
    chk({tag, ".empty"}, 64'(ras_empty), 64'(cnt == 0));
    chk({tag, ".full"},  64'(ras_full),  64'(cnt == 4));
    chk({tag, ".ovf"},   64'(ras_ovf),   64'(ovf));
    chk({tag, ".unf"},   64'(ras_unf),   64'(unf));
  endtask

  // Apply one cycle of controls, sample 1 time unit after the edge, then idle the inputs
  task automatic cyc(input logic st, input logic br, input logic [31:0] off,
                     input logic jp, input logic lk, input logic rt,
                     input logic [25:0] jv);
    stall = st; branch = br; branch_off = off; jump = jp; link = lk; ret = rt;
    jump_value = jv;
    @(posedge clk); #1;
    stall = 0; branch = 0; branch_off = 0; jump = 0; link = 0; ret = 0;
    jump_value = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; stall = 0; branch = 0; branch_off = 0; jump = 0; link = 0;
    ret = 0; jump_value = 0;
    #1;
    chk("reset.pc", 64'(pc), 64'h0);
    chk_ras("reset", 0, 0, 0);
    #1 reset = 0;

    // Sequential count
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq1", 64'(pc), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq2", 64'(pc), 64'd2);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq3", 64'(pc), 64'd3);
    chk("seq.empty", 64'(ras_empty), 64'd1);

    // link without jump is ignored; jump to 10, then branch -5 -> 6
    cyc(0, 0, 0, 0, 1, 0, 26'd7); chk("link_only", 64'(pc), 64'd4);
    chk("link_only.count", 64'(ras_count), 64'd0);
    cyc(0, 0, 0, 1, 0, 0, 26'd10); chk("jump10", 64'(pc), 64'd10);
    cyc(0, 1, 32'hFFFF_FFFB, 0, 0, 0, 0); chk("br_m5", 64'(pc), 64'd6);
    // 6 - 8 + 1 = all ones, then silent wrap to 0
    cyc(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0); chk("br_m8", 64'(pc), 64'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("wrap", 64'(pc), 64'h0);

    // Reach 0x0400_0010: jump to 0x10, then branch +0x03FF_FFFF
    cyc(0, 0, 0, 1, 0, 0, 26'h10); chk("j10", 64'(pc), 64'h10);
    cyc(0, 1, 32'h03FF_FFFF, 0, 0, 0, 0); chk("br_big", 64'(pc), 64'h0400_0010);
    cyc(0, 0, 0, 1, 1, 0, 26'h100); chk("jal", 64'(pc), 64'h0400_0100);
    chk_ras("jal", 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("ret", 64'(pc), 64'h0400_0011);
    chk_ras("ret", 0, 0, 0);

    // Five JALs into a 4-deep stack
    cyc(0, 0, 0, 1, 1, 0, 26'h20); chk("jal1", 64'(pc), 64'h0400_0020);
    cyc(0, 0, 0, 1, 1, 0, 26'h30); chk("jal2", 64'(pc), 64'h0400_0030);
    cyc(0, 0, 0, 1, 1, 0, 26'h40); chk("jal3", 64'(pc), 64'h0400_0040);
    cyc(0, 0, 0, 1, 1, 0, 26'h50); chk("jal4", 64'(pc), 64'h0400_0050);
    chk_ras("jal4", 4, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 26'h60); chk("jal5", 64'(pc), 64'h0400_0060);
    chk_ras("jal5", 4, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("pop5", 64'(pc), 64'h0400_0051);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("pop4", 64'(pc), 64'h0400_0041);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("pop3", 64'(pc), 64'h0400_0031);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("pop2", 64'(pc), 64'h0400_0021);
    chk_ras("pop2", 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("pop_unf", 64'(pc), 64'h0400_0022);
    chk_ras("pop_unf", 0, 1, 1);

    // Stall with everything asserted, then ret beating jump+link
    cyc(0, 0, 0, 1, 1, 0, 26'h70); chk("jal6", 64'(pc), 64'h0400_0070);
    cyc(0, 0, 0, 1, 1, 0, 26'h80); chk("jal7", 64'(pc), 64'h0400_0080);
    cyc(1, 1, 32'h10, 1, 1, 1, 26'h99); chk("stall", 64'(pc), 64'h0400_0080);
    chk_ras("stall", 2, 1, 1);
    cyc(0, 0, 0, 1, 1, 1, 26'h90); chk("ret_jal", 64'(pc), 64'h0400_0071);
    chk_ras("ret_jal", 1, 1, 1);

    // Async reset mid-cycle while stalled
    cyc(0, 0, 0, 1, 1, 0, 26'hA0); chk("jal8", 64'(pc), 64'h0400_00A0);
    chk("jal8.count", 64'(ras_count), 64'd2);
    stall = 1;
    #2 reset = 1;
    #1;
    chk("areset.pc", 64'(pc), 64'h0);
    chk_ras("areset", 0, 0, 0);
    #1 reset = 0; stall = 0;
    cyc(0, 0, 0, 0, 0, 0, 0); chk("post_rst", 64'(pc), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("post_rst_ret", 64'(pc), 64'd2);
    chk_ras("post_rst_ret", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
